// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control codes, flag
// bit positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLTU   = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b1010;
    localparam logic [3:0] ALU_SRL    = 4'b1011;
    localparam logic [3:0] ALU_SRA    = 4'b1100;
    localparam logic [3:0] ALU_OP_MAX = 4'b1100;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_REFEREE = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_unsupported(input logic [3:0] op);
        return op > ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first valid requester at or
// after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant_idx,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic               any
);

    always_comb begin
        grant_idx = '0;
        grant_oh  = '0;
        any       = 1'b0;
        // Walk from the farthest offset down so the nearest valid one overwrites last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % NUM_REQ]) begin
                grant_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
                grant_oh  = '0;
                grant_oh[(int'(ptr) + k) % NUM_REQ] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: accept one op, present
// it to the ALU for a cycle, then hold the tagged result until it is taken.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]      req_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [3:0]                alu_control,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    input  logic                      alu_carry,
    input  logic                      alu_referee,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [2:0]                rsp_flags,
    output logic                      rsp_err
);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh),
        .any       (grant_any)
    );

    assign req_ready = (state == ST_IDLE && grant_any) ? grant_oh : '0;
    assign rsp_id    = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        alu_a       <= req_a[grant_idx*DATA_W +: DATA_W];
                        alu_b       <= req_b[grant_idx*DATA_W +: DATA_W];
                        alu_control <= req_op[grant_idx*4 +: 4];
                        id_q        <= grant_idx;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result              <= alu_result;
                    rsp_flags[FLAG_ZERO]    <= alu_zero;
                    rsp_flags[FLAG_CARRY]   <= alu_carry;
                    rsp_flags[FLAG_REFEREE] <= alu_referee;
                    rsp_err                 <= op_unsupported(alu_control);
                    rsp_valid               <= 1'b1;
                    state                   <= ST_RESP;
                end
                ST_RESP: begin
                    // Priority rotates past the owner only once its result is consumed.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
module tb_alu_share_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N*4-1:0]  req_op = '0;
    logic [31:0]   alu_a, alu_b, alu_result;
    logic [3:0]    alu_control;
    logic          alu_zero, alu_carry, alu_referee;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_result;
    logic [2:0]    rsp_flags;
    logic          rsp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(32), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_referee(alu_referee),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // Behavioural ALU: carry only meaningful for ADD; unsupported codes give 0.
    always_comb begin
        logic [32:0] sum;
        logic        v;
        sum = '0;
        v = 1'b0;
        alu_carry = 1'b0;
        case (alu_control)
            4'b0000: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry = sum[32];
                v = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            4'b0001: begin
                sum[31:0] = alu_a - alu_b;
                v = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
            end
            4'b0010: sum[31:0] = alu_a & alu_b;
            4'b0011: sum[31:0] = alu_a | alu_b;
            4'b0100: sum[31:0] = alu_a ^ alu_b;
            4'b0101: sum[31:0] = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0110: sum[31:0] = {31'd0, alu_a < alu_b};
            4'b1010: sum[31:0] = alu_a << alu_b[4:0];
            4'b1011: sum[31:0] = alu_a >> alu_b[4:0];
            4'b1100: sum[31:0] = $signed(alu_a) >>> alu_b[4:0];
            default: sum = '0;
        endcase
        alu_result  = sum[31:0];
        alu_zero    = (sum[31:0] == 32'd0);
        alu_referee = sum[31] ^ v;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_op[idx*4 +: 4]  = op;
        req_valid[idx]      = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready[idx]) begin
                tick();
                req_valid[idx] = 1'b0;
                return;
            end
            tick();
        end
        check("send_timeout", {63'd0, req_ready[idx]}, 64'd1);
        req_valid[idx] = 1'b0;
    endtask

    // Raise every requester in mask at once and track grant/response order.
    task automatic serve_order(input string tag, input logic [N-1:0] mask,
                               input logic [7:0] order, input int cnt);
        int k;
        int r;
        int last;
        logic [N-1:0] snap;
        k = 0;
        r = 0;
        last = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_a[i*32 +: 32] = 32'(100 + i);
                req_b[i*32 +: 32] = 32'(i);
                req_op[i*4 +: 4]  = 4'b0000;
            end
        end
        req_valid = req_valid | mask;
        for (int cyc = 0; cyc < 40 && (k < cnt || r < cnt); cyc++) begin
            #1;
            snap = req_ready;
            if (snap != '0) begin
                check({tag, "_grant"}, 64'(snap), 64'(4'b0001 << order[2*k +: 2]));
                if (k > 0) check({tag, "_spacing"}, 64'(cyc - last), 64'd3);
                last = cyc;
                k++;
            end
            if (rsp_valid) begin
                check({tag, "_id"}, 64'(rsp_id), 64'(order[2*r +: 2]));
                check({tag, "_result"}, 64'(rsp_result), 64'(100 + 2 * int'(order[2*r +: 2])));
                r++;
            end
            tick();
            req_valid = req_valid & ~snap;
        end
        check({tag, "_grants"}, 64'(k), 64'(cnt));
        check({tag, "_rsps"}, 64'(r), 64'(cnt));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: requester 0 ADD 5+7
        req_a[31:0] = 32'd5;
        req_b[31:0] = 32'd7;
        req_op[3:0] = 4'b0000;
        req_valid[0] = 1'b1;
        #1;
        check("t1_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid[0] = 1'b0;
        check("t1_exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t1_exec_req_ready", 64'(req_ready), 64'd0);
        check("t1_alu_a", 64'(alu_a), 64'd5);
        check("t1_alu_b", 64'(alu_b), 64'd7);
        check("t1_alu_control", 64'(alu_control), 64'd0);
        tick();
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_rsp_id", 64'(rsp_id), 64'd0);
        check("t1_rsp_result", 64'(rsp_result), 64'd12);
        check("t1_rsp_flags", 64'(rsp_flags), 64'b000);
        check("t1_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        check("t1_rsp_drop", 64'(rsp_valid), 64'd0);

        // 2: requester 2 SUB 0-1
        send(2, 32'd0, 32'd1, 4'b0001);
        tick();
        check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t2_rsp_id", 64'(rsp_id), 64'd2);
        check("t2_rsp_result", 64'(rsp_result), 64'hFFFF_FFFF);
        check("t2_rsp_flags", 64'(rsp_flags), 64'b100);
        tick();

        // 3: all four from reset, served 0,1,2,3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        serve_order("t3", 4'b1111, 8'hE4, 4);

        // 4: after id 2, requesters 0 and 3 together -> 3 then 0
        send(2, 32'd1, 32'd1, 4'b0000);
        tick();
        check("t4_pre_id", 64'(rsp_id), 64'd2);
        tick();
        serve_order("t4", 4'b1001, 8'h03, 2);

        // 5: backpressure in RESP with another requester waiting
        rsp_ready = 1'b0;
        req_a[95:64] = 32'd102;
        req_b[95:64] = 32'd2;
        req_op[11:8] = 4'b0000;
        req_valid[2] = 1'b1;
        send(1, 32'h10, 32'h20, 4'b0011);
        tick();
        for (int n = 0; n < 5; n++) begin
            check("t5_hold_valid", 64'(rsp_valid), 64'd1);
            check("t5_hold_result", 64'(rsp_result), 64'h30);
            check("t5_hold_id", 64'(rsp_id), 64'd1);
            check("t5_hold_req_ready", 64'(req_ready), 64'd0);
            check("t5_hold_alu_a", 64'(alu_a), 64'h10);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("t5_rsp_drop", 64'(rsp_valid), 64'd0);
        #1;
        check("t5_resume_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid[2] = 1'b0;
        tick();
        check("t5_next_id", 64'(rsp_id), 64'd2);
        check("t5_next_result", 64'(rsp_result), 64'd104);
        tick();

        // 6: unsupported op from requester 1
        send(1, 32'h1234, 32'h5678, 4'b1110);
        tick();
        check("t6_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t6_rsp_id", 64'(rsp_id), 64'd1);
        check("t6_rsp_result", 64'(rsp_result), 64'd0);
        check("t6_rsp_flags", 64'(rsp_flags), 64'b001);
        check("t6_rsp_err", 64'(rsp_err), 64'd1);
        tick();

        // 6b: reset during EXEC drops the transaction
        send(0, 32'd5, 32'd5, 4'b0000);
        check("t6b_pre_alu_a", 64'(alu_a), 64'd5);
        rst_n = 1'b0;
        #1;
        check("t6b_alu_a", 64'(alu_a), 64'd0);
        check("t6b_alu_b", 64'(alu_b), 64'd0);
        check("t6b_alu_control", 64'(alu_control), 64'd0);
        check("t6b_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6b_req_ready", 64'(req_ready), 64'd0);
        check("t6b_rsp_flags", 64'(rsp_flags), 64'd0);
        check("t6b_rsp_err", 64'(rsp_err), 64'd0);
        check("t6b_rsp_result", 64'(rsp_result), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("t6b_no_rsp", 64'(rsp_valid), 64'd0);
        end
        req_valid = 4'b1111;
        #1;
        check("t6b_ptr_zero", 64'(req_ready), 64'b0001);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
